// File: rtl/map_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// map_write_scheduler_if
//   Bundles the tile-map write scheduler's requester handshakes, the clear
//   control and the tile-map RAM write port.
//
//   blank                       display blanking (write window when gated)
//   reqN_valid/ready/addr/tex   requester N: tile index (row*20+col) + texture
//   clear_start/clear_tex       start a fill of all 300 tiles with clear_tex
//   clear_busy                  fill in progress
//   map_we/map_waddr/map_wdata  registered tile-map RAM write port
//   addr_err                    one-cycle pulse for an accepted addr >= 300
//
//   master : requesters / display side (drives requests, observes results)
//   slave  : the scheduler
// ---------------------------------------------------------------------------
interface map_write_scheduler_if;
  logic       blank;

  logic       req0_valid;
  logic       req0_ready;
  logic [8:0] req0_addr;
  logic [3:0] req0_tex;

  logic       req1_valid;
  logic       req1_ready;
  logic [8:0] req1_addr;
  logic [3:0] req1_tex;

  logic       clear_start;
  logic [3:0] clear_tex;
  logic       clear_busy;

  logic       map_we;
  logic [8:0] map_waddr;
  logic [3:0] map_wdata;
  logic       addr_err;

  modport master (
    output blank,
    output req0_valid, req0_addr, req0_tex,
    output req1_valid, req1_addr, req1_tex,
    output clear_start, clear_tex,
    input  req0_ready, req1_ready,
    input  clear_busy,
    input  map_we, map_waddr, map_wdata, addr_err
  );

  modport slave (
    input  blank,
    input  req0_valid, req0_addr, req0_tex,
    input  req1_valid, req1_addr, req1_tex,
    input  clear_start, clear_tex,
    output req0_ready, req1_ready,
    output clear_busy,
    output map_we, map_waddr, map_wdata, addr_err
  );
endinterface

// File: rtl/map_write_scheduler.sv
// ---------------------------------------------------------------------------
// map_write_scheduler
//   Arbitrates two tile-map write requesters onto a single registered write
//   port of the 20x15 tile-map RAM, and can fill the whole map (300 tiles)
//   with one texture.
//
//   Ports
//     pclk   pixel clock, all state changes on its rising edge
//     reset  synchronous, active-high
//     bus    map_write_scheduler_if.slave (requests, clear control, RAM port)
//
//   Build option
//     MAP_WRITE_BLANK_ONLY_EN  when defined, writes (requests and fill) only
//                              happen while blank=1, so the visible map never
//                              tears; otherwise blank is ignored.
//
//   Arbitration: with both requesters valid the one not granted last wins;
//   a lone valid requester always wins. last_grant resets to 1 so
//   requester 0 takes the first tie.
// ---------------------------------------------------------------------------
module map_write_scheduler (
  input  logic                 pclk,
  input  logic                 reset,
  map_write_scheduler_if.slave bus
);

  localparam int         NUM_REQ   = 2;
  localparam logic [8:0] NUM_TILES = 9'd300;
  localparam logic [8:0] LAST_TILE = 9'd299;

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic [8:0] addr;
    logic [3:0] tex;
  } wr_req_t;

  state_t               state, state_nxt;
  logic [8:0]           cnt, cnt_nxt;
  logic [3:0]           clr_tex;
  logic                 last_grant;   // 1: requester 1 took the last transfer
  logic                 win;
  logic                 accept_ok;
  logic [NUM_REQ-1:0]   req_vld;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rdy;
  wr_req_t [NUM_REQ-1:0] req;
  wr_req_t              sel;
  logic                 xfer;
  logic                 in_range;
  logic                 fill_wr;
  logic                 clr_go;

  logic                 we_q;
  logic [8:0]           waddr_q;
  logic [3:0]           wdata_q;
  logic                 err_q;
  logic                 busy_q;

  // ---- write window -------------------------------------------------------
`ifdef MAP_WRITE_BLANK_ONLY_EN
  assign win = bus.blank;
`else
  logic blank_unused;
  assign blank_unused = bus.blank;
  assign win          = 1'b1;
`endif

  // ---- request arbitration ------------------------------------------------
  assign req_vld = {bus.req1_valid, bus.req0_valid};
  assign req[0]  = '{addr: bus.req0_addr, tex: bus.req0_tex};
  assign req[1]  = '{addr: bus.req1_addr, tex: bus.req1_tex};

  // On a tie the requester that did not take the last transfer wins.
  assign gnt[0] = req_vld[0] & (~req_vld[1] |  last_grant);
  assign gnt[1] = req_vld[1] & (~req_vld[0] | ~last_grant);

  // clear_start wins over requests in the same cycle; reset masks ready.
  assign accept_ok = (state == IDLE) & win & ~bus.clear_start & ~reset;
  assign rdy       = gnt & {NUM_REQ{accept_ok}};

  assign xfer     = |rdy;
  assign sel      = rdy[1] ? req[1] : req[0];
  assign in_range = (sel.addr < NUM_TILES);

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];

  // ---- FSM: state register ------------------------------------------------
  always_ff @(posedge pclk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---- FSM: next state ----------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fill_wr   = 1'b0;
    clr_go    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.clear_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
          clr_go    = 1'b1;
        end
      end
      CLEAR: begin
        // Fill pauses (cnt holds) whenever the window is closed.
        if (win) begin
          fill_wr = 1'b1;
          if (cnt == LAST_TILE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 9'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- registered write port / status ------------------------------------
  always_ff @(posedge pclk) begin
    if (reset) begin
      last_grant <= 1'b1;
      clr_tex    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // Requests only transfer in IDLE, fills only happen in CLEAR, so the
      // two write sources are never active together.
      we_q   <= fill_wr | (xfer & in_range);
      err_q  <= xfer & ~in_range;
      busy_q <= (state_nxt == CLEAR);
      if (clr_go)
        clr_tex <= bus.clear_tex;
      if (fill_wr) begin
        waddr_q <= cnt;
        wdata_q <= clr_tex;
      end else if (xfer & in_range) begin
        waddr_q <= sel.addr;
        wdata_q <= sel.tex;
      end
      if (xfer)
        last_grant <= rdy[1];
    end
  end

  assign bus.map_we     = we_q;
  assign bus.map_waddr  = waddr_q;
  assign bus.map_wdata  = wdata_q;
  assign bus.addr_err   = err_q;
  assign bus.clear_busy = busy_q;

endmodule

// File: tb/tb_map_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_map_write_scheduler
//   Directed scenarios followed by random traffic, all checked against a
//   transaction-level reference model (arbitration rule, fill progress,
//   expected next-cycle write) kept in this bench.
// ---------------------------------------------------------------------------
module tb_map_write_scheduler;
  logic pclk  = 1'b0;
  logic reset = 1'b1;

  map_write_scheduler_if bus();

  map_write_scheduler dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
  );

  always #20 pclk = ~pclk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit         m_fill;
  int         m_pos;
  logic [3:0] m_tex;
  bit         m_last = 1'b1;
  bit         e_we, e_err;
  logic [8:0] e_waddr;
  logic [3:0] e_wdata;
  bit         x0, x1;        // model transfers in the last step
  bit         d_r1;          // DUT req1_ready seen in the last step
  int         dut_we_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return 9'd299;
      1:       return 9'd300;
      2:       return 9'd511;
      default: return 9'($urandom_range(0, 299));
    endcase
  endfunction

  // Inputs are already driven (just after a falling edge). Checks the
  // combinational readies, advances the model one clock, checks registers.
  task automatic step();
    bit win, g0, g1, r0, r1;
    logic [8:0] a;
    logic [3:0] t;
    #1;
`ifdef MAP_WRITE_BLANK_ONLY_EN
    win = bus.blank;
`else
    win = 1'b1;
`endif
    g0 = bus.req0_valid && (!bus.req1_valid || m_last);
    g1 = bus.req1_valid && (!bus.req0_valid || !m_last);
    r0 = !m_fill && win && !bus.clear_start && g0;
    r1 = !m_fill && win && !bus.clear_start && g1;
    chk("req0_ready", bus.req0_ready, r0);
    chk("req1_ready", bus.req1_ready, r1);
    d_r1 = bus.req1_ready;
    x0 = r0;
    x1 = r1;
    e_we  = 1'b0;
    e_err = 1'b0;
    if (!m_fill) begin
      if (bus.clear_start) begin
        m_fill = 1'b1;
        m_pos  = 0;
        m_tex  = bus.clear_tex;
      end else if (r0 || r1) begin
        a = r1 ? bus.req1_addr : bus.req0_addr;
        t = r1 ? bus.req1_tex  : bus.req0_tex;
        if (a < 9'd300) begin
          e_we = 1'b1; e_waddr = a; e_wdata = t;
        end else begin
          e_err = 1'b1;
        end
        m_last = r1;
      end
    end else if (win) begin
      e_we = 1'b1; e_waddr = 9'(m_pos); e_wdata = m_tex;
      if (m_pos == 299) m_fill = 1'b0;
      else              m_pos++;
    end
    @(posedge pclk);
    #1;
    chk("map_we", bus.map_we, e_we);
    chk("addr_err", bus.addr_err, e_err);
    chk("clear_busy", bus.clear_busy, m_fill);
    if (e_we) begin
      chk("map_waddr", bus.map_waddr, e_waddr);
      chk("map_wdata", bus.map_wdata, e_wdata);
    end
    if (bus.map_we) dut_we_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_ready1", bus.req1_ready, 1'b0);
    @(posedge pclk);
    #1;
    chk("rst_we", bus.map_we, 1'b0);
    chk("rst_err", bus.addr_err, 1'b0);
    chk("rst_busy", bus.clear_busy, 1'b0);
    chk("rst_waddr", bus.map_waddr, 9'd0);
    chk("rst_wdata", bus.map_wdata, 4'd0);
    m_fill = 1'b0; m_pos = 0; m_last = 1'b1;
    x0 = 1'b0; x1 = 1'b0;
    @(negedge pclk);
    reset = 1'b0;
  endtask

  // Runs the fill to completion (or until stop_at is reached), bounded.
  task automatic run_fill(input int stop_at, input bit blank_gap);
    int i;
    i = 0;
    while (m_fill && m_pos != stop_at && i < 1000) begin
      @(negedge pclk);
      bus.clear_start = 1'b0;
      bus.blank = !(blank_gap && i >= 100 && i < 110);
      if (i == 50) begin bus.clear_start = 1'b1; bus.clear_tex = 4'hA; end
      step();
      i++;
    end
    bus.clear_start = 1'b0;
    bus.blank = 1'b1;
    if (i >= 1000) chk("fill_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] order;
    bus.blank = 1'b1;
    bus.clear_start = 1'b0; bus.clear_tex = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_tex = '0;
    bus.req0_valid = 1'b1; bus.req0_addr = 9'd21; bus.req0_tex = 4'd5;
    do_reset();

    // single request, immediate grant and write
    step();
    chk("t33_we", bus.map_we, 1'b1);
    chk("t33_waddr", bus.map_waddr, 9'd21);
    chk("t33_wdata", bus.map_wdata, 4'd5);

    // tie stream: grants must alternate starting with requester 0
    bus.req0_valid = 1'b0;
    do_reset();
    order = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      bus.req0_valid = 1'b1; bus.req0_addr = 9'(10 + i); bus.req0_tex = 4'(i);
      bus.req1_valid = 1'b1; bus.req1_addr = 9'(200 + i); bus.req1_tex = 4'(8 + i);
      step();
      order[i] = d_r1;
    end
    chk("t34_order", order, 4'b1010);

    // out-of-range address consumed with an error pulse
    @(negedge pclk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_addr = 9'd300; bus.req1_tex = 4'd6;
    step();
    chk("t35_err", bus.addr_err, 1'b1);
    @(negedge pclk);
    bus.req1_addr = 9'd7; bus.req1_tex = 4'd9;
    step();
    chk("t35_next_we", bus.map_we, 1'b1);
    bus.req1_valid = 1'b0;

    // full clear beats a pending request; re-trigger mid-fill is ignored
    @(negedge pclk);
    bus.req0_valid = 1'b1; bus.req0_addr = 9'd50; bus.req0_tex = 4'd2;
    bus.clear_start = 1'b1; bus.clear_tex = 4'd3;
    step();
    dut_we_cnt = 0;
    run_fill(-1, 1'b1);
    chk("t36_writes", dut_we_cnt, 300);
    @(negedge pclk);
    step();
    chk("t36_req0_after", bus.map_we, 1'b1);
    bus.req0_valid = 1'b0;

    // reset aborts a fill at 150; a new clear restarts at tile 0
    @(negedge pclk);
    bus.clear_start = 1'b1; bus.clear_tex = 4'd12;
    step();
    run_fill(150, 1'b0);
    do_reset();
    @(negedge pclk);
    bus.clear_start = 1'b1; bus.clear_tex = 4'd1;
    step();
    @(negedge pclk);
    bus.clear_start = 1'b0;
    step();
    chk("t38_restart_addr", bus.map_waddr, 9'd0);
    run_fill(-1, 1'b0);

    // random traffic; requesters hold their request until transferred
    for (int c = 0; c < 4000; c++) begin
      @(negedge pclk);
      if (x0 || !bus.req0_valid) begin
        bus.req0_valid = ($urandom_range(0, 3) != 0);
        bus.req0_addr  = rnd_addr();
        bus.req0_tex   = 4'($urandom);
      end
      if (x1 || !bus.req1_valid) begin
        bus.req1_valid = ($urandom_range(0, 3) != 0);
        bus.req1_addr  = rnd_addr();
        bus.req1_tex   = 4'($urandom);
      end
      bus.clear_start = ($urandom_range(0, 249) == 0);
      bus.clear_tex   = 4'($urandom);
      bus.blank       = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
